// File: rtl/dcm_seq_pkg.sv
// ============================================================================
// dcm_seq_pkg : state encoding and counter sizing for dcm_lock_sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

package dcm_seq_pkg;

    typedef enum logic [2:0] {
        S_RST    = 3'd0,
        S_WAIT   = 3'd1,
        S_SETTLE = 3'd2,
        S_PWUP   = 3'd3,
        S_CAMRST = 3'd4,
        S_RUN    = 3'd5,
        S_FAIL   = 3'd6
    } state_t;

    // Bits needed to count 0..max_cycles-1 (at least one bit).
    function automatic int cnt_width(input int max_cycles);
        return (max_cycles <= 2) ? 1 : $clog2(max_cycles);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// sync_2ff : 1-bit two-stage synchronizer, asynchronous reset to 0
// Rev 1.0
// ============================================================================
`default_nettype none

module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= i_d;
            sync_q <= meta_q;
        end
    end

    assign o_q = sync_q;

endmodule

`default_nettype wire

// File: rtl/dcm_lock_sequencer.sv
// ============================================================================
// dcm_lock_sequencer : DCM reset/lock supervisor and CMOS sensor power-up
// sequencer with bounded retries and a sticky failure state.  Rev 1.0
// ============================================================================
`default_nettype none

module dcm_lock_sequencer
    import dcm_seq_pkg::*;
#(
    parameter int RST_CYCLES      = 8,
    parameter int LOCK_TIMEOUT    = 50000,
    parameter int SETTLE_CYCLES   = 1024,
    parameter int CAM_PWUP_CYCLES = 50000,
    parameter int CAM_RST_CYCLES  = 50000,
    parameter int MAX_RETRIES     = 3
) (
    input  logic                               clk,
    input  logic                               RESET,
    input  logic                               dcm_locked,
    output logic                               dcm_rst,
    output logic                               cmos_pwdn,
    output logic                               cmos_rst_n,
    output logic                               clk_ready,
    output logic                               lock_fail,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt,
    output logic [2:0]                         state
);

    localparam int RW = $clog2(MAX_RETRIES + 1);
    localparam int CW = cnt_width(max2(max2(max2(RST_CYCLES, LOCK_TIMEOUT),
                                            max2(SETTLE_CYCLES, CAM_PWUP_CYCLES)),
                                       CAM_RST_CYCLES));

    localparam logic [CW-1:0] c_rst_last    = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] c_wait_last   = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] c_settle_last = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] c_pwup_last   = CW'(CAM_PWUP_CYCLES - 1);
    localparam logic [CW-1:0] c_camrst_last = CW'(CAM_RST_CYCLES - 1);
    localparam logic [RW-1:0] c_retry_max   = RW'(MAX_RETRIES);

    logic          w_lk;
    logic          w_retry_evt;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          dcm_rst_q, dcm_rst_d;
    logic          cmos_pwdn_q, cmos_pwdn_d;
    logic          cmos_rst_n_q, cmos_rst_n_d;
    logic          clk_ready_q, clk_ready_d;
    logic          lock_fail_q, lock_fail_d;

    sync_2ff u_lock_sync (
        .clk (clk),
        .rst (RESET),
        .i_d (dcm_locked),
        .o_q (w_lk)
    );

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state_q      <= S_RST;
            cnt_q        <= '0;
            retry_q      <= '0;
            dcm_rst_q    <= 1'b1;
            cmos_pwdn_q  <= 1'b1;
            cmos_rst_n_q <= 1'b0;
            clk_ready_q  <= 1'b0;
            lock_fail_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retry_q      <= retry_d;
            dcm_rst_q    <= dcm_rst_d;
            cmos_pwdn_q  <= cmos_pwdn_d;
            cmos_rst_n_q <= cmos_rst_n_d;
            clk_ready_q  <= clk_ready_d;
            lock_fail_q  <= lock_fail_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        retry_d     = retry_q;
        w_retry_evt = 1'b0;

        // Lock loss is tested before terminal count so it wins a tie; in
        // S_WAIT lock arriving wins over the timeout.
        case (state_q)
            S_RST:    if (cnt_q == c_rst_last) state_d = S_WAIT;
            S_WAIT: begin
                if (w_lk)                      state_d = S_SETTLE;
                else if (cnt_q == c_wait_last) w_retry_evt = 1'b1;
            end
            S_SETTLE: begin
                if (!w_lk)                       w_retry_evt = 1'b1;
                else if (cnt_q == c_settle_last) state_d = S_PWUP;
            end
            S_PWUP: begin
                if (!w_lk)                     w_retry_evt = 1'b1;
                else if (cnt_q == c_pwup_last) state_d = S_CAMRST;
            end
            S_CAMRST: begin
                if (!w_lk)                       w_retry_evt = 1'b1;
                else if (cnt_q == c_camrst_last) state_d = S_RUN;
            end
            S_RUN:    if (!w_lk) w_retry_evt = 1'b1;
            S_FAIL:   state_d = S_FAIL;
            default:  state_d = S_RST;
        endcase

        if (w_retry_evt) begin
            if (retry_q == c_retry_max) begin
                state_d = S_FAIL;
            end else begin
                retry_d = retry_q + 1'b1;
                state_d = S_RST;
            end
        end

        if (state_d == S_RUN && state_q != S_RUN) begin
            retry_d = '0;
        end

        // Saturate so long stays in S_RUN/S_FAIL cannot wrap the counter.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end

        dcm_rst_d    = (state_d == S_RST) || (state_d == S_FAIL);
        cmos_pwdn_d  = !(state_d inside {S_PWUP, S_CAMRST, S_RUN});
        cmos_rst_n_d = (state_d == S_CAMRST) || (state_d == S_RUN);
        clk_ready_d  = (state_d == S_RUN);
        lock_fail_d  = (state_d == S_FAIL);
    end

    assign dcm_rst    = dcm_rst_q;
    assign cmos_pwdn  = cmos_pwdn_q;
    assign cmos_rst_n = cmos_rst_n_q;
    assign clk_ready  = clk_ready_q;
    assign lock_fail  = lock_fail_q;
    assign retry_cnt  = retry_q;
    assign state      = state_q;

endmodule

`default_nettype wire
